// File: rtl/usb_uart_pkg.sv
// Shared definitions for the USB-to-UART transmit path: the default bit period
// and the transmitter state encoding.
package usb_uart_pkg;

  // 48 MHz system clock divided down to 115200 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 416;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/usb_uart_tx_fifo.sv
// Synchronous byte FIFO between the USB side and the UART shifter.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module usb_uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO or a pop from an empty one is dropped here as well,
  // so a misbehaving caller can never corrupt the pointers.
  assign do_push = push && (level != LVL_FULL);
  assign do_pop  = pop  && (level != '0);
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the pointers and level alone define
  // which entries are valid, and leaving it unreset lets it map to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/usb_uart_tx.sv
// Buffered UART transmitter fed by the USB OUT path: 8N1 frames, or 8E1 when
// the build defines UART_TX_PARITY_EN.
module usb_uart_tx
  import usb_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [7:0]                    out_data,
  input  logic                          out_valid,
  output logic                          out_ready,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [2:0]    BIT_ONE   = 3'd1;

  tx_state_t    state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]   bit_idx;
  logic [7:0]   shreg;
`ifdef UART_TX_PARITY_EN
  logic         parity_bit;
`endif
  logic [7:0]   head;
  logic         push;
  logic         pop;
  logic         bit_done;

  assign out_ready = (fifo_level != LVL_FULL);
  assign push      = out_valid && out_ready;
  assign bit_done  = (baud_cnt == '0);
  assign tx_busy   = (state != ST_IDLE) || (fifo_level != '0);

  // The head byte is consumed on the same edge that enters START, either from
  // IDLE or straight out of a finished stop bit for gap-free streaming.
  assign pop = (fifo_level != '0) &&
               ((state == ST_IDLE) || ((state == ST_STOP) && bit_done));

  usb_uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .push      (push),
    .push_data (out_data),
    .pop       (pop),
    .head      (head),
    .level     (fifo_level)
  );

  // uart_tx is loaded together with the state it belongs to, so the line is a
  // flop output and never glitches.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= ST_IDLE;
      uart_tx    <= 1'b1;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            state      <= ST_START;
            baud_cnt   <= BAUD_LAST;
            shreg      <= head;
`ifdef UART_TX_PARITY_EN
            parity_bit <= even_parity(head);
`endif
            uart_tx    <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_done) begin
            state    <= ST_DATA;
            baud_cnt <= BAUD_LAST;
            bit_idx  <= '0;
            uart_tx  <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt - BAUD_ONE;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            baud_cnt <= BAUD_LAST;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state   <= ST_PARITY;
              uart_tx <= parity_bit;
`else
              state   <= ST_STOP;
              uart_tx <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + BIT_ONE;
              shreg   <= {1'b0, shreg[7:1]};
              uart_tx <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt - BAUD_ONE;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_done) begin
            state    <= ST_STOP;
            baud_cnt <= BAUD_LAST;
            uart_tx  <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt - BAUD_ONE;
          end
        end
`endif
        ST_STOP: begin
          if (bit_done) begin
            if (pop) begin
              state      <= ST_START;
              baud_cnt   <= BAUD_LAST;
              shreg      <= head;
`ifdef UART_TX_PARITY_EN
              parity_bit <= even_parity(head);
`endif
              uart_tx    <= 1'b0;
            end else begin
              state   <= ST_IDLE;
              uart_tx <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - BAUD_ONE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_uart_tx.sv
// Directed bench for usb_uart_tx: waveform, streaming, wrap, simultaneous
// push/pop and reset-abort scenarios against a line decoder.
module tb_usb_uart_tx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    out_data = 8'h00;
  logic          out_valid = 1'b0;
  logic          out_ready;
  logic          uart_tx;
  logic          tx_busy;
  logic [LW-1:0] fifo_level;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  bit mute     = 1'b0;
  logic [7:0] rx_q[$];
  int         start_q[$];

  usb_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .uart_tx    (uart_tx),
    .tx_busy    (tx_busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Line decoder: finds a falling edge, then samples each bit at its centre.
  initial begin : decoder
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!rst && uart_tx === 1'b0) begin
        start_q.push_back(cyc);
        repeat (CPB/2) @(negedge clk);
        if (!mute) check("rx_start_mid", int'(uart_tx), 0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        if (!mute) check("rx_parity", int'(uart_tx), int'(^b));
`endif
        repeat (CPB) @(negedge clk);
        if (!mute) begin
          check("rx_stop", int'(uart_tx), 1);
          rx_q.push_back(b);
        end
      end
    end
  end

  task automatic clear_rx();
    rx_q.delete();
    start_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (tx_busy && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, int'(tx_busy), 0);
  endtask

  // One byte from idle; checks the whole line waveform cycle by cycle.
  task automatic send_one(input string tag, input logic [7:0] d);
    logic [FRAME_BITS-1:0] exp_bits;
    int match;
    int busy_n = 0;
    exp_bits[0]   = 1'b0;
    exp_bits[8:1] = d;
`ifdef UART_TX_PARITY_EN
    exp_bits[9]   = ^d;
`endif
    exp_bits[FRAME_BITS-1] = 1'b1;
    clear_rx();
    out_data  = d;
    out_valid = 1'b1;
    tick();
    out_valid = 1'b0;
    check({tag, "_level_after_push"}, int'(fifo_level), 1);
    check({tag, "_line_high_at_accept"}, int'(uart_tx), 1);
    for (int k = 0; k < FRAME_BITS; k++) begin
      match = 0;
      for (int c = 0; c < CPB; c++) begin
        tick();
        if (uart_tx === exp_bits[k]) match++;
        if (tx_busy) busy_n++;
      end
      check($sformatf("%s_bit%0d", tag, k), match, CPB);
    end
    check({tag, "_busy_cycles"}, busy_n, FRAME_CYC);
    tick();
    check({tag, "_busy_dropped"}, int'(tx_busy), 0);
    check({tag, "_idle_high"}, int'(uart_tx), 1);
    check({tag, "_rx_count"}, rx_q.size(), 1);
    if (rx_q.size() > 0) check({tag, "_rx_byte"}, int'(rx_q[0]), int'(d));
  endtask

  // Keeps out_valid high throughout; while full, drives junk data that must be ignored.
  task automatic stream(input string tag, input int n, input logic [7:0] first);
    int sent = 0;
    int guard = 0;
    bit full_seen = 1'b0;
    bit rdy;
    clear_rx();
    while (sent < n && guard < 50 * FRAME_CYC) begin
      rdy = out_ready;
      if (!full_seen && fifo_level == LW'(DEPTH)) begin
        full_seen = 1'b1;
        check({tag, "_ready_low_when_full"}, int'(out_ready), 0);
      end
      out_valid = 1'b1;
      out_data  = rdy ? first + 8'(sent) : 8'hEE;
      tick();
      if (rdy) sent++;
      guard++;
    end
    out_valid = 1'b0;
    check({tag, "_all_sent"}, sent, n);
    check({tag, "_full_reached"}, int'(full_seen), 1);
    wait_idle(tag, (n + 2) * FRAME_CYC);
    check({tag, "_rx_count"}, rx_q.size(), n);
    for (int i = 0; i < n && i < rx_q.size(); i++)
      check($sformatf("%s_rx%0d", tag, i), int'(rx_q[i]), int'(first + 8'(i)));
    for (int i = 1; i < start_q.size(); i++)
      check($sformatf("%s_gap%0d", tag, i), start_q[i] - start_q[i-1], FRAME_CYC);
  endtask

  initial begin
    int lows;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_uart_tx", int'(uart_tx), 1);
    check("rst_level", int'(fifo_level), 0);
    check("rst_busy", int'(tx_busy), 0);
    rst = 1'b0;
    check("ready_after_reset", int'(out_ready), 1);
    tick();
    check("idle_line_high", int'(uart_tx), 1);

    send_one("f55", 8'h55);
    stream("b2b", 8, 8'h00);
    stream("wrap", 20, 8'h30);

    // Simultaneous push and pop at level 2: the stop->start edge pops while D is pushed.
    clear_rx();
    out_data = 8'h11; out_valid = 1'b1; tick();
    out_valid = 1'b0; tick();
    check("sim_start_low", int'(uart_tx), 0);
    out_data = 8'h22; out_valid = 1'b1; tick();
    out_data = 8'h33; tick();
    out_valid = 1'b0;
    check("sim_level2", int'(fifo_level), 2);
    repeat (FRAME_CYC - 3) @(posedge clk);
    #1;
    check("sim_level_before", int'(fifo_level), 2);
    check("sim_in_stop", int'(uart_tx), 1);
    out_data = 8'h44; out_valid = 1'b1; tick();
    out_valid = 1'b0;
    check("sim_level_kept", int'(fifo_level), 2);
    check("sim_no_gap", int'(uart_tx), 0);
    wait_idle("sim", 5 * FRAME_CYC);
    check("sim_rx_count", rx_q.size(), 4);
    if (rx_q.size() == 4) begin
      check("sim_rx0", int'(rx_q[0]), 8'h11);
      check("sim_rx1", int'(rx_q[1]), 8'h22);
      check("sim_rx2", int'(rx_q[2]), 8'h33);
      check("sim_rx3", int'(rx_q[3]), 8'h44);
    end

    // Reset in the middle of data bit 3 of 0xA5 with two bytes queued.
    clear_rx();
    mute = 1'b1;
    out_data = 8'hA5; out_valid = 1'b1; tick();
    out_valid = 1'b0; tick();
    out_data = 8'h5A; out_valid = 1'b1; tick();
    out_data = 8'h3C; tick();
    out_valid = 1'b0;
    check("abort_queued", int'(fifo_level), 2);
    repeat (1 + 4*CPB + CPB/2 - 3) @(posedge clk);
    #1;
    check("abort_bit3_value", int'(uart_tx), 0);
    rst = 1'b1;
    tick();
    check("abort_line_high", int'(uart_tx), 1);
    check("abort_level0", int'(fifo_level), 0);
    check("abort_busy0", int'(tx_busy), 0);
    tick();
    rst = 1'b0;
    check("abort_ready", int'(out_ready), 1);
    lows = 0;
    for (int c = 0; c < 3 * FRAME_CYC; c++) begin
      tick();
      if (uart_tx !== 1'b1) lows++;
    end
    mute = 1'b0;
    for (int c = 0; c < FRAME_CYC; c++) begin
      tick();
      if (uart_tx !== 1'b1) lows++;
    end
    check("abort_no_frames", lows, 0);
    check("abort_rx_empty", rx_q.size(), 0);

    send_one("f07", 8'h07);
    send_one("f03", 8'h03);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
